// File: rtl/bvh_prim_dispatch.sv
// bvh_prim_dispatch: turns leaf ranges {start, count} delivered by the BVH
// traversal unit into a stream of single primitive indices for the tester.
// Ranges are held in a small circular queue; the head entry is walked with
// an offset register until its last primitive is handed off.
// Optional feature: define BVH_PRIM_LEAF_MERGE_EN to coalesce a pushed range
// into the queue tail when the two ranges are contiguous.
module bvh_prim_dispatch #(
  parameter int PRIM_INDEX_W  = 16,
  parameter int PRIM_AMOUNT_W = 8,
  parameter int QUEUE_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         restart_strobe,
  input  logic                         leaf_valid,
  input  logic [PRIM_INDEX_W-1:0]      start_prim [2],
  input  logic [PRIM_AMOUNT_W-1:0]     num_prim [2],
  output logic                         leaf_ready,
  input  logic                         bvh_finished,
  output logic                         prim_valid,
  output logic [PRIM_INDEX_W-1:0]      prim_index,
  input  logic                         prim_ready,
  output logic                         done,
  output logic [$clog2(QUEUE_DEPTH):0] queue_count
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef BVH_PRIM_LEAF_MERGE_EN
  localparam bit MergeEn = 1'b1;
`else
  localparam bit MergeEn = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [PRIM_INDEX_W-1:0]  start_mem [QUEUE_DEPTH];
  logic [PRIM_AMOUNT_W-1:0] count_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]         occ_q, occ_d;
  logic [PRIM_AMOUNT_W-1:0] offset_q, offset_d;

  logic                     accept, push0, push1, hs, pop;
  logic [1:0]               n_alloc;
  logic                     wa_en, wb_en;
  logic [PTR_W-1:0]         wa_idx, wb_idx, vt_idx;
  logic [PRIM_INDEX_W-1:0]  wa_start, wb_start, vt_start;
  logic [PRIM_AMOUNT_W-1:0] wa_cnt, wb_cnt, vt_cnt;
  logic                     vt_ok;

  // A range may extend the tail when it starts right where the tail ends and
  // the combined count still fits in a count field.
  function automatic logic can_merge(input logic                     ok,
                                     input logic [PRIM_INDEX_W-1:0]  t_start,
                                     input logic [PRIM_AMOUNT_W-1:0] t_cnt,
                                     input logic [PRIM_INDEX_W-1:0]  s,
                                     input logic [PRIM_AMOUNT_W-1:0] n);
    logic [PRIM_AMOUNT_W:0] sum;
    sum = {1'b0, t_cnt} + {1'b0, n};
    return MergeEn && ok && ((t_start + PRIM_INDEX_W'(t_cnt)) == s) && !sum[PRIM_AMOUNT_W];
  endfunction

  // Ready is taken from the registered count, so two slots always fit.
  assign leaf_ready  = (occ_q <= CNT_W'(QUEUE_DEPTH - 2));
  assign queue_count = occ_q;
  assign accept      = leaf_valid && leaf_ready && (state_q != S_DONE) && !restart_strobe;
  assign push0       = accept && (num_prim[0] != '0);
  assign push1       = accept && (num_prim[1] != '0);
  assign hs          = (state_q == S_ISSUE) && prim_ready;
  assign pop         = hs && (offset_q == (count_mem[head_q] - PRIM_AMOUNT_W'(1)));
  assign prim_index  = prim_valid ? (start_mem[head_q] + PRIM_INDEX_W'(offset_q)) : '0;

  // Decide where each accepted slot lands: merged into the tail or a new entry.
  // NOTE: every variable of an always_comb is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wa_en    = 1'b0;
    wa_idx   = tail_q;
    wa_start = start_prim[0];
    wa_cnt   = num_prim[0];
    wb_en    = 1'b0;
    wb_idx   = tail_q;
    wb_start = start_prim[1];
    wb_cnt   = num_prim[1];
    n_alloc  = 2'd0;
    vt_ok    = (occ_q >= CNT_W'(2));
    vt_idx   = tail_q - PTR_W'(1);
    vt_start = start_mem[vt_idx];
    vt_cnt   = count_mem[vt_idx];
    if (push0) begin
      wa_en = 1'b1;
      if (can_merge(vt_ok, vt_start, vt_cnt, start_prim[0], num_prim[0])) begin
        wa_idx   = vt_idx;
        wa_start = vt_start;
        wa_cnt   = vt_cnt + num_prim[0];
      end else begin
        n_alloc = 2'd1;
      end
      vt_ok    = 1'b1;
      vt_start = wa_start;
      vt_cnt   = wa_cnt;
    end
    if (push1) begin
      if (can_merge(vt_ok, vt_start, vt_cnt, start_prim[1], num_prim[1])) begin
        wa_en    = 1'b1;
        wa_idx   = push0 ? wa_idx : vt_idx;
        wa_start = vt_start;
        wa_cnt   = vt_cnt + num_prim[1];
      end else begin
        wb_en   = 1'b1;
        wb_idx  = tail_q + PTR_W'(n_alloc);
        n_alloc = n_alloc + 2'd1;
      end
    end
  end

  // Pointer, occupancy and offset next state; restart flushes everything.
  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q + PTR_W'(n_alloc);
    occ_d    = occ_q + CNT_W'(n_alloc) - CNT_W'(pop);
    offset_d = offset_q;
    if (hs) begin
      if (pop) begin
        offset_d = '0;
        head_d   = head_q + PTR_W'(1);
      end else begin
        offset_d = offset_q + PRIM_AMOUNT_W'(1);
      end
    end
    if (restart_strobe) begin
      head_d   = '0;
      tail_d   = '0;
      occ_d    = '0;
      offset_d = '0;
    end
  end

  // FSM next state and the outputs decoded from the current state.
  always_comb begin
    state_d    = state_q;
    prim_valid = (state_q == S_ISSUE);
    done       = (state_q == S_DONE);
    if (restart_strobe) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ISSUE: begin
          if (occ_d != '0)       state_d = S_ISSUE;
          else if (bvh_finished) state_d = S_DONE;
          else                   state_d = S_IDLE;
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Queue control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      occ_q    <= '0;
      offset_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      occ_q    <= occ_d;
      offset_q <= offset_d;
    end
  end

  // Range storage writes.
  // NOTE: the storage array has no reset; entries are only read once occupancy marks them written.
  always_ff @(posedge clk) begin
    if (wa_en) begin
      start_mem[wa_idx] <= wa_start;
      count_mem[wa_idx] <= wa_cnt;
    end
    if (wb_en) begin
      start_mem[wb_idx] <= wb_start;
      count_mem[wb_idx] <= wb_cnt;
    end
  end

endmodule

// File: doc/bvh_prim_dispatch.md
BVH_PRIM_DISPATCH -- requirements
Module: bvh_prim_dispatch

Interface
REQ-001 SHALL have parameter PRIM_INDEX_W, default 16, primitive index width.
REQ-002 SHALL have parameter PRIM_AMOUNT_W, default 8, per-leaf primitive count width.
REQ-003 SHALL have parameter QUEUE_DEPTH, default 4, leaf-range queue entries (power of 2, >=2).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port restart_strobe  input  1  synchronous flush for a new ray.
REQ-007 SHALL have port leaf_valid  input  1  start_prim/num_prim pair valid this cycle.
REQ-008 SHALL have port start_prim[2]  input  PRIM_INDEX_W each  first primitive of leaf slot 0/1.
REQ-009 SHALL have port num_prim[2]  input  PRIM_AMOUNT_W each  primitive count of slot 0/1, 0 = empty.
REQ-010 SHALL have port leaf_ready  output  1  queue has >=2 free entries.
REQ-011 SHALL have port bvh_finished  input  1  traversal unit finished, level signal.
REQ-012 SHALL have port prim_valid  output  1  prim_index valid.
REQ-013 SHALL have port prim_index  output  PRIM_INDEX_W  primitive to test.
REQ-014 SHALL have port prim_ready  input  1  primitive tester accepts prim_index.
REQ-015 SHALL have port done  output  1  ray fully dispatched.
REQ-016 SHALL have port queue_count  output  clog2(QUEUE_DEPTH)+1  occupied entries.

Function
REQ-017 Accept SHALL occur on leaf_valid && leaf_ready; slots with num_prim != 0 SHALL be pushed, slot 0 before slot 1; zero-count slots SHALL be discarded.
REQ-018 leaf_valid while !leaf_ready SHALL be ignored (no push, no error).
REQ-019 Entry = {start, count}; head entry carries an issue offset register, 0 on load.
REQ-020 States: IDLE (queue empty, !done), ISSUE (queue non-empty), DONE.
REQ-021 IDLE->ISSUE on any push; IDLE->DONE when bvh_finished && queue empty; ISSUE->IDLE when last entry pops with no simultaneous push; ISSUE->DONE when last entry pops and bvh_finished; DONE holds until restart_strobe.
REQ-022 prim_valid SHALL equal (state==ISSUE); prim_index SHALL equal head.start + offset, modulo 2^PRIM_INDEX_W (wrap, no saturation).
REQ-023 Latency: a range pushed at edge N into an empty queue SHALL present prim_valid at cycle N+1.
REQ-024 On prim_valid && prim_ready: offset<count-1 -> offset+1; offset==count-1 -> pop head, offset=0.
REQ-025 prim_index SHALL stay stable while prim_valid && !prim_ready.
REQ-026 Simultaneous push and pop SHALL be legal; queue_count changes by pushes minus pops; leaf_ready computed from registered count (conservative).
REQ-027 done SHALL be 1 only in DONE; leaf_valid in DONE SHALL be ignored.
REQ-028 restart_strobe SHALL dominate all events: queue emptied, offset=0, state=IDLE, prim_valid=0 next cycle; same-cycle leaf_valid discarded.

Reset
REQ-029 reset SHALL asynchronously force: state IDLE, queue empty, offset 0, prim_valid 0, prim_index 0, done 0, queue_count 0, leaf_ready 1.
REQ-030 reset asserted mid-issue SHALL drop all pending ranges; no primitive issued until a new push after reset release.

Configuration
REQ-031 Macro BVH_PRIM_LEAF_MERGE_EN: when defined, a pushed range with start == tail.start+tail.count (tail not head-in-issue) and merged count <= 2^PRIM_AMOUNT_W-1 SHALL extend tail.count instead of allocating; slot 1 may merge into slot 0 same cycle.
REQ-032 Without BVH_PRIM_LEAF_MERGE_EN every non-empty slot SHALL allocate its own entry; issued index sequence SHALL be identical in both builds.

Verification
REQ-033 Reset, push {start 10,n 3},{start 40,n 0}, prim_ready=1 -> prim_index 10,11,12 on consecutive cycles, then IDLE, queue_count 0.
REQ-034 Push {0xFFFE,n 3} -> indices 0xFFFE,0xFFFF,0x0000.
REQ-035 Push 2 pairs of 2-prim ranges with prim_ready=0 -> queue_count 4, leaf_ready 0, third leaf_valid ignored; release ready -> 8 indices in push order.
REQ-036 bvh_finished=1 with last index handshaked -> done=1 next cycle; restart_strobe -> done=0, IDLE.
REQ-037 restart_strobe during ISSUE with 3 pending entries plus same-cycle leaf_valid -> prim_valid 0, queue_count 0 next cycle.
REQ-038 With BVH_PRIM_LEAF_MERGE_EN: push {8,n 2},{10,n 3} -> queue_count 1, indices 8..12; without macro -> queue_count 2, same indices.
